frontend_test_checker: RTL and testbench

Sink-side checker for the front-end test sample stream. Receives left/right 24-bit samples and valid strobes on the same interface the front-end test source drives, and verifies the content against the selected test mode: positive DC, negative DC, or triangle. Reports error counts, lock status and the measured sample interval to the control registers. Sits downstream of the front-end mux and in parallel with the DSP input, so firmware can self-test the sample path.

---
 rtl/frontend_test_checker.sv | 189 ++++++++++++++++++
 tb/tb_frontend_test_checker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_test_checker.sv
// Sink-side checker for the front-end test sample stream: verifies DC and triangle
// content, L/R agreement, and reports error counts, lock status and sample timing.
module frontend_test_checker #(
  parameter int                  NUM_BITS  = 24,
  parameter logic [NUM_BITS-1:0] TRI_LIMIT = 24'h7ffffe,
  parameter logic [NUM_BITS-1:0] POS_DC    = 24'h7fff00,
  parameter logic [NUM_BITS-1:0] NEG_DC    = 24'h8000ff
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [1:0]          check_mode,
  input  logic [7:0]          triangle_incrmnt,
  input  logic                l_valid,
  input  logic                r_valid,
  input  logic [NUM_BITS-1:0] l_data,
  input  logic [NUM_BITS-1:0] r_data,
  output logic                locked,
  output logic [15:0]         error_count,
  output logic [15:0]         lr_mismatch_count,
  output logic [10:0]         sample_interval,
  output logic [23:0]         sample_count
);

  localparam int W = NUM_BITS + 1;

  typedef enum logic [1:0] {
    ACQUIRE    = 2'd0,
    DIRSEEK    = 2'd1,
    TRACK_UP   = 2'd2,
    TRACK_DOWN = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_BITS-1:0] prev_reg, prev_next;
  logic                locked_next;
  logic [1:0]          mode_prev_reg;
  logic [10:0]         interval_cnt_reg;

  logic         sample;
  logic         mode_change;
  logic         tri_err;
  logic         dc_err;
  logic         content_err;
  logic         lr_event;

  logic [W-1:0] inc;
  logic [W-1:0] prev_w;
  logic [W-1:0] sample_w;
  logic [W-1:0] p_plus;
  logic [W-1:0] p_minus;
  logic         up_go;
  logic         dn_go;
  logic [W-1:0] up_val;
  logic [W-1:0] dn_val;
  logic         up_hit;
  logic         dn_hit;

  assign sample      = l_valid;
  assign mode_change = (check_mode != mode_prev_reg);

  // Both predictions share one adder and one subtractor; all math is 25-bit unsigned.
  assign inc      = {{(W-8){1'b0}}, triangle_incrmnt};
  assign prev_w   = {1'b0, prev_reg};
  assign sample_w = {1'b0, l_data};
  assign p_plus   = prev_w + inc;
  assign p_minus  = prev_w - inc;

  assign up_go  = (p_plus < {1'b0, TRI_LIMIT});
  assign up_val = up_go ? p_plus : p_minus;
  // A borrow in prev - inc means the descent cannot continue.
  assign dn_go  = (prev_w >= inc) && (p_minus > inc);
  assign dn_val = dn_go ? p_minus : p_plus;

  assign up_hit = (sample_w == up_val);
  assign dn_hit = (sample_w == dn_val);

  // Triangle tracker: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ACQUIRE;
      prev_reg  <= '0;
      locked    <= 1'b0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      locked    <= locked_next;
    end
  end

  // Triangle tracker: next state, lock and error decision
  always_comb begin
    state_next  = state_reg;
    prev_next   = prev_reg;
    locked_next = locked;
    tri_err     = 1'b0;
    if (clear || mode_change) begin
      state_next  = ACQUIRE;
      locked_next = 1'b0;
    end else if (check_mode == 2'd3 && sample) begin
      prev_next = l_data;
      case (state_reg)
        ACQUIRE: begin
          state_next = DIRSEEK;
        end
        DIRSEEK: begin
          if (up_hit) begin
            state_next  = up_go ? TRACK_UP : TRACK_DOWN;
            locked_next = 1'b1;
          end else if (dn_hit) begin
            state_next  = dn_go ? TRACK_DOWN : TRACK_UP;
            locked_next = 1'b1;
          end else begin
            tri_err = 1'b1;
          end
        end
        TRACK_UP: begin
          if (up_hit) begin
            state_next  = up_go ? TRACK_UP : TRACK_DOWN;
            locked_next = 1'b1;
          end else begin
            state_next  = DIRSEEK;
            locked_next = 1'b0;
            tri_err     = 1'b1;
          end
        end
        TRACK_DOWN: begin
          if (dn_hit) begin
            state_next  = dn_go ? TRACK_DOWN : TRACK_UP;
            locked_next = 1'b1;
          end else begin
            state_next  = DIRSEEK;
            locked_next = 1'b0;
            tri_err     = 1'b1;
          end
        end
        default: begin
          state_next  = ACQUIRE;
          locked_next = 1'b0;
        end
      endcase
    end
  end

  assign dc_err = sample &&
                  (((check_mode == 2'd1) && (l_data != POS_DC)) ||
                   ((check_mode == 2'd2) && (l_data != NEG_DC)));
  assign content_err = dc_err || tri_err;

  // A right strobe without a left one is also a disagreement.
  assign lr_event = (check_mode != 2'd0) &&
                    ((l_valid && (!r_valid || (r_data != l_data))) ||
                     (r_valid && !l_valid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_prev_reg     <= 2'd0;
      error_count       <= '0;
      lr_mismatch_count <= '0;
      sample_interval   <= '0;
      sample_count      <= '0;
      interval_cnt_reg  <= '0;
    end else begin
      mode_prev_reg <= check_mode;
      if (clear) begin
        error_count       <= '0;
        lr_mismatch_count <= '0;
        sample_interval   <= '0;
        sample_count      <= '0;
        interval_cnt_reg  <= '0;
      end else begin
        if (content_err && (error_count != 16'hffff)) begin
          error_count <= error_count + 16'd1;
        end
        if (lr_event && (lr_mismatch_count != 16'hffff)) begin
          lr_mismatch_count <= lr_mismatch_count + 16'd1;
        end
        if (sample) begin
          sample_count     <= sample_count + 24'd1;
          sample_interval  <= (interval_cnt_reg == 11'h7ff) ? 11'h7ff : interval_cnt_reg + 11'd1;
          interval_cnt_reg <= '0;
        end else if (interval_cnt_reg != 11'h7ff) begin
          interval_cnt_reg <= interval_cnt_reg + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frontend_test_checker.sv
// Self-checking bench for frontend_test_checker: directed scenarios plus a random
// phase, all compared every cycle against an arithmetic reference model.
module tb_frontend_test_checker;

  localparam longint TRI_LIMIT = 64'h7ffffe;
  localparam logic [23:0] POS_DC = 24'h7fff00;
  localparam logic [23:0] NEG_DC = 24'h8000ff;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [1:0]  check_mode;
  logic [7:0]  triangle_incrmnt;
  logic        l_valid;
  logic        r_valid;
  logic [23:0] l_data;
  logic [23:0] r_data;
  logic        locked;
  logic [15:0] error_count;
  logic [15:0] lr_mismatch_count;
  logic [10:0] sample_interval;
  logic [23:0] sample_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_err, m_lr, m_int, m_cnt;
  int unsigned m_count;
  logic [1:0]  m_mode_prev;
  int          m_phase;   // 0 acquire, 1 seeking direction, 2 tracking
  bit          m_up;
  bit          m_locked;
  longint      m_prev;

  frontend_test_checker dut (
    .clk               (clk),
    .reset             (reset),
    .clear             (clear),
    .check_mode        (check_mode),
    .triangle_incrmnt  (triangle_incrmnt),
    .l_valid           (l_valid),
    .r_valid           (r_valid),
    .l_data            (l_data),
    .r_data            (r_data),
    .locked            (locked),
    .error_count       (error_count),
    .lr_mismatch_count (lr_mismatch_count),
    .sample_interval   (sample_interval),
    .sample_count      (sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next value of an ideal triangle from p in direction up.
  function automatic void tri_next(input longint p, input bit up, input longint inc,
                                   output longint v, output bit nup);
    if (up) begin
      if (p + inc < TRI_LIMIT) begin v = p + inc; nup = 1'b1; end
      else begin v = p - inc; nup = 1'b0; end
    end else begin
      if (p - inc > inc) begin v = p - inc; nup = 1'b0; end
      else begin v = p + inc; nup = 1'b1; end
    end
  endfunction

  task automatic model_zero();
    m_err = 0; m_lr = 0; m_int = 0; m_cnt = 0; m_count = 0;
    m_phase = 0; m_locked = 1'b0;
  endtask

  task automatic model_step();
    bit     chg, bad, d1, d2;
    longint l, v1, v2, inc;
    if (reset) begin
      model_zero();
      m_mode_prev = 2'd0;
      m_prev = 0;
      return;
    end
    chg = (check_mode != m_mode_prev);
    m_mode_prev = check_mode;
    if (clear) begin
      model_zero();
      return;
    end
    if (check_mode != 0 &&
        ((l_valid && (!r_valid || r_data != l_data)) || (r_valid && !l_valid)))
      if (m_lr < 65535) m_lr++;
    if (l_valid) begin
      m_count = (m_count + 1) % (1 << 24);
      m_int = (m_cnt + 1 > 2047) ? 2047 : m_cnt + 1;
      m_cnt = 0;
    end else if (m_cnt < 2047) m_cnt++;
    bad = 1'b0;
    if (l_valid && check_mode == 1 && l_data != POS_DC) bad = 1'b1;
    if (l_valid && check_mode == 2 && l_data != NEG_DC) bad = 1'b1;
    if (chg) begin
      m_phase = 0; m_locked = 1'b0;
    end else if (check_mode == 3 && l_valid) begin
      l = longint'(l_data);
      inc = longint'(triangle_incrmnt);
      if (m_phase == 1) begin
        tri_next(m_prev, 1'b1, inc, v1, d1);
        tri_next(m_prev, 1'b0, inc, v2, d2);
        if (l == v1) begin m_phase = 2; m_up = d1; m_locked = 1'b1; end
        else if (l == v2) begin m_phase = 2; m_up = d2; m_locked = 1'b1; end
        else bad = 1'b1;
      end else if (m_phase == 2) begin
        tri_next(m_prev, m_up, inc, v1, d1);
        if (l == v1) begin m_up = d1; m_locked = 1'b1; end
        else begin bad = 1'b1; m_locked = 1'b0; m_phase = 1; end
      end else m_phase = 1;
      m_prev = l;
    end
    if (bad && m_err < 65535) m_err++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("error_count", {16'd0, error_count}, m_err);
    chk("lr_mismatch_count", {16'd0, lr_mismatch_count}, m_lr);
    chk("sample_interval", {21'd0, sample_interval}, m_int);
    chk("sample_count", {8'd0, sample_count}, m_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_sample(input logic [23:0] l, input logic [23:0] r);
    l_valid = 1'b1; r_valid = 1'b1; l_data = l; r_data = r;
    tick();
    l_valid = 1'b0; r_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Ideal triangle from start; sample g (if >= 0) is corrupted by +1 LSB.
  task automatic tri_run(input longint start, input bit up, input int n, input int g);
    longint      p, v;
    bit          d, nd, exp_lock;
    logic [23:0] s;
    p = start; d = up;
    for (int i = 0; i < n; i++) begin
      s = p[23:0];
      if (i == g) s = s + 24'd1;
      drive_sample(s, s);
      exp_lock = (i >= 1) && !(g >= 0 && (i == g || i == g + 1));
      chk("tri_locked", {31'd0, locked}, {31'd0, exp_lock});
      tri_next(p, d, longint'(triangle_incrmnt), v, nd);
      p = v; d = nd;
    end
  endtask

  initial begin
    longint rp, rv;
    bit     rd, rnd;
    logic [23:0] ld;

    reset = 1'b1; clear = 1'b0; check_mode = 2'd0; triangle_incrmnt = 8'h80;
    l_valid = 1'b0; r_valid = 1'b0; l_data = '0; r_data = '0;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_error", {16'd0, error_count}, 32'd0);
    chk("rst_lr", {16'd0, lr_mismatch_count}, 32'd0);
    chk("rst_interval", {21'd0, sample_interval}, 32'd0);
    chk("rst_count", {8'd0, sample_count}, 32'd0);

    // DC pass, mode 1, strobe every 1116 clocks
    check_mode = 2'd1;
    idle(2);
    do_clear();
    for (int i = 0; i < 4; i++) begin
      drive_sample(POS_DC, POS_DC);
      idle(1115);
    end
    chk("dcpass_error", {16'd0, error_count}, 32'd0);
    chk("dcpass_lr", {16'd0, lr_mismatch_count}, 32'd0);
    chk("dcpass_interval", {21'd0, sample_interval}, 32'd1116);
    chk("dcpass_count", {8'd0, sample_count}, 32'd4);

    // DC fault, mode 2
    check_mode = 2'd2;
    idle(2);
    do_clear();
    for (int i = 1; i <= 25; i++) begin
      drive_sample((i == 20) ? 24'h000000 : NEG_DC, (i == 10) ? 24'h8000fe : NEG_DC);
      idle(2);
    end
    chk("dcfault_lr", {16'd0, lr_mismatch_count}, 32'd2);
    chk("dcfault_error", {16'd0, error_count}, 32'd1);
    chk("dcfault_interval", {21'd0, sample_interval}, 32'd3);

    // Triangle lock: from 0, across the top turn, across the bottom turn
    check_mode = 2'd3;
    triangle_incrmnt = 8'h80;
    idle(2);
    do_clear();
    tri_run(0, 1'b1, 300, -1);
    do_clear();
    tri_run(64'h7ff000, 1'b1, 200, -1);
    do_clear();
    tri_run(64'h1800, 1'b0, 200, -1);
    chk("trilock_error", {16'd0, error_count}, 32'd0);

    // Triangle glitch mid-ramp
    do_clear();
    tri_run(64'h100000, 1'b1, 20, 10);
    chk("glitch_error", {16'd0, error_count}, 32'd2);

    // Mode change 3 -> 1 -> 3 while locked
    check_mode = 2'd1;
    idle(2);
    chk("modechg_unlock", {31'd0, locked}, 32'd0);
    check_mode = 2'd3;
    idle(2);
    tri_run(64'h200000, 1'b1, 10, -1);
    chk("modechg_error", {16'd0, error_count}, 32'd2);

    // Reset mid-ramp
    l_valid = 1'b1; r_valid = 1'b1; l_data = 24'h200800; r_data = 24'h200800;
    reset = 1'b1;
    idle(2);
    reset = 1'b0; l_valid = 1'b0; r_valid = 1'b0;
    #1;
    chk("midrst_error", {16'd0, error_count}, 32'd0);
    chk("midrst_count", {8'd0, sample_count}, 32'd0);
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    idle(1);

    // Random phase against the model
    triangle_incrmnt = 8'h40;
    rp = 64'h400000; rd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) check_mode = 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 499) == 0);
      l_valid = $urandom_range(0, 1);
      rnd = ($urandom_range(0, 7) == 0);
      if (check_mode == 3) ld = rp[23:0];
      else if (check_mode == 1) ld = POS_DC;
      else ld = NEG_DC;
      if (rnd) ld = 24'($urandom);
      l_data = ld;
      r_valid = ($urandom_range(0, 9) == 0) ? !l_valid : l_valid;
      r_data = ($urandom_range(0, 9) == 0) ? 24'($urandom) : ld;
      if (l_valid && check_mode == 3) begin
        tri_next(rp, rd, 64'h40, rv, rd);
        rp = rv;
      end
      tick();
    end
    clear = 1'b0; l_valid = 1'b0; r_valid = 1'b0;

    // Interval saturation
    idle(2100);
    drive_sample(24'h0, 24'h0);
    chk("interval_sat", {21'd0, sample_interval}, 32'h7ff);

    // Counter saturation in mode 1, then clear coincident with a strobe
    check_mode = 2'd1;
    idle(2);
    do_clear();
    for (int i = 0; i < 65540; i++) drive_sample(24'h000000, 24'h000001);
    chk("sat_error", {16'd0, error_count}, 32'hffff);
    chk("sat_lr", {16'd0, lr_mismatch_count}, 32'hffff);
    chk("sat_count", {8'd0, sample_count}, 32'd65540);
    clear = 1'b1;
    drive_sample(24'h000000, 24'h000001);
    clear = 1'b0;
    chk("clr_error", {16'd0, error_count}, 32'd0);
    chk("clr_lr", {16'd0, lr_mismatch_count}, 32'd0);
    chk("clr_count", {8'd0, sample_count}, 32'd0);
    chk("clr_interval", {21'd0, sample_interval}, 32'd0);
    drive_sample(POS_DC, POS_DC);
    chk("post_clr_count", {8'd0, sample_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
